change_dispenser: RTL and testbench

// - Downstream stage of the coin-counting FSM. Consumes its soda strobe and 3-bit change code.
// - Drives the soda door actuator, then ejects change as individual nickels.
// - Coin-hopper handshake is one request/ack pair per nickel, with timeout and fault reporting.

---
 rtl/change_dispenser.sv | 152 +++++++++++++++
 tb/tb_change_dispenser.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Soda door and nickel-change dispenser fed by the coin-counting FSM.
// Optional CHANGE_DISP_TALLY_EN adds saturating soda/nickel tally outputs.
module change_dispenser #(
    parameter int CHANGE_W    = 3,
    parameter int VEND_CYCLES = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                soda_i,
    input  logic [CHANGE_W-1:0] change_i,
    input  logic                eject_ack_i,
    input  logic                hopper_empty_i,
    input  logic                fault_clr_i,
    output logic                vend_o,
    output logic                eject_o,
    output logic                busy_o,
    output logic [CHANGE_W-1:0] coins_left_o,
    output logic                fault_o,
    output logic                dropped_o
`ifdef CHANGE_DISP_TALLY_EN
    ,
    output logic [15:0]         sodas_o,
    output logic [15:0]         nickels_o
`endif
);

    localparam int VT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam int AT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_EJECT,
        S_GAP,
        S_FAULT
    } state_t;

    state_t              state_reg;
    logic                soda_q;
    logic [CHANGE_W-1:0] cnt_reg;
    logic [VT_W-1:0]     vend_timer_reg;
    logic [AT_W-1:0]     ack_timer_reg;
    logic                soda_evt;

    assign soda_evt     = soda_i & ~soda_q;
    assign coins_left_o = cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_IDLE;
            soda_q         <= 1'b0;
            cnt_reg        <= '0;
            vend_timer_reg <= '0;
            ack_timer_reg  <= '0;
            vend_o         <= 1'b0;
            eject_o        <= 1'b0;
            busy_o         <= 1'b0;
            fault_o        <= 1'b0;
            dropped_o      <= 1'b0;
        end else begin
            soda_q <= soda_i;
            case (state_reg)
                S_IDLE: begin
                    if (soda_evt) begin
                        state_reg      <= S_VEND;
                        cnt_reg        <= change_i;
                        vend_timer_reg <= VT_W'(VEND_CYCLES - 1);
                        vend_o         <= 1'b1;
                        busy_o         <= 1'b1;
                    end
                end
                S_VEND: begin
                    if (vend_timer_reg == '0) begin
                        vend_o <= 1'b0;
                        if (cnt_reg == '0) begin
                            state_reg <= S_IDLE;
                            busy_o    <= 1'b0;
                        end else begin
                            state_reg     <= S_EJECT;
                            eject_o       <= 1'b1;
                            ack_timer_reg <= '0;
                        end
                    end else begin
                        vend_timer_reg <= vend_timer_reg - VT_W'(1);
                    end
                end
                S_EJECT: begin
                    // ack takes priority over both empty and timeout
                    if (eject_ack_i) begin
                        state_reg <= S_GAP;
                        eject_o   <= 1'b0;
                        if (cnt_reg != '0) cnt_reg <= cnt_reg - CHANGE_W'(1);
                    end else if (hopper_empty_i ||
                                 ack_timer_reg == AT_W'(ACK_TIMEOUT - 1)) begin
                        state_reg <= S_FAULT;
                        eject_o   <= 1'b0;
                        fault_o   <= 1'b1;
                    end else begin
                        ack_timer_reg <= ack_timer_reg + AT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        state_reg     <= S_EJECT;
                        eject_o       <= 1'b1;
                        ack_timer_reg <= '0;
                    end
                end
                S_FAULT: begin
                    if (fault_clr_i) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                        fault_o   <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    vend_o    <= 1'b0;
                    eject_o   <= 1'b0;
                    busy_o    <= 1'b0;
                    fault_o   <= 1'b0;
                end
            endcase

            // a clear in the same cycle as a busy event wins
            if (fault_clr_i)
                dropped_o <= 1'b0;
            else if (soda_evt && state_reg != S_IDLE)
                dropped_o <= 1'b1;
        end
    end

`ifdef CHANGE_DISP_TALLY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sodas_o   <= '0;
            nickels_o <= '0;
        end else begin
            if (state_reg == S_IDLE && soda_evt && sodas_o != 16'hFFFF)
                sodas_o <= sodas_o + 16'd1;
            if (state_reg == S_EJECT && eject_ack_i && nickels_o != 16'hFFFF)
                nickels_o <= nickels_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expectations queued at stimulus time, popped as outputs appear.
module tb_change_dispenser;

    localparam int CHANGE_W    = 3;
    localparam int VEND_CYCLES = 8;
    localparam int ACK_TIMEOUT = 255;
    localparam int TRACE_LEN   = 40;

    logic                clk_i          = 1'b0;
    logic                rst_ni         = 1'b0;
    logic                soda_i         = 1'b0;
    logic [CHANGE_W-1:0] change_i       = '0;
    logic                eject_ack_i    = 1'b0;
    logic                hopper_empty_i = 1'b0;
    logic                fault_clr_i    = 1'b0;
    logic                vend_o;
    logic                eject_o;
    logic                busy_o;
    logic [CHANGE_W-1:0] coins_left_o;
    logic                fault_o;
    logic                dropped_o;
`ifdef CHANGE_DISP_TALLY_EN
    logic [15:0]         sodas_o;
    logic [15:0]         nickels_o;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    change_dispenser #(
        .CHANGE_W    (CHANGE_W),
        .VEND_CYCLES (VEND_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .soda_i         (soda_i),
        .change_i       (change_i),
        .eject_ack_i    (eject_ack_i),
        .hopper_empty_i (hopper_empty_i),
        .fault_clr_i    (fault_clr_i),
        .vend_o         (vend_o),
        .eject_o        (eject_o),
        .busy_o         (busy_o),
        .coins_left_o   (coins_left_o),
        .fault_o        (fault_o),
        .dropped_o      (dropped_o)
`ifdef CHANGE_DISP_TALLY_EN
        ,
        .sodas_o        (sodas_o),
        .nickels_o      (nickels_o)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_obs(input string tag, input int got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({"sb_unexpected_", tag}, got, -1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "/", tag}, got, e.val);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        fault_clr_i = 1'b1;
        @(negedge clk_i);
        fault_clr_i = 1'b0;
    endtask

    task automatic wait_eject(input string tag);
        int n;
        n = 0;
        while (!eject_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        sb_obs({tag, "_eject_seen"}, int'(eject_o));
    endtask

    task automatic soda_pulse(input int change);
        @(negedge clk_i);
        soda_i   = 1'b1;
        change_i = CHANGE_W'(change);
        @(negedge clk_i);
        soda_i   = 1'b0;
    endtask

    // Full vend + acked ejection trace, recorded cycle by cycle from the soda edge.
    task automatic run_trace(input int change, input int hold_len, input bit inject);
        int v[TRACE_LEN+1], e[TRACE_LEN+1], c[TRACE_LEN+1], b[TRACE_LEN+1];
        int vend_lat, vend_len, vend_runs, pulses, busy_end, t, len, fall;
        bit first;

        sb_push("vend_lat", 1);
        sb_push("vend_len", VEND_CYCLES);
        sb_push("vend_runs", 1);
        if (change > 0) sb_push("eject_lat", VEND_CYCLES + 1);
        for (int k = 0; k < change; k++) begin
            sb_push("eject_len", 1);
            sb_push("coins_after", change - k - 1);
            if (k < change - 1) sb_push("gap_len", 1);
        end
        sb_push("eject_count", change);
        sb_push("busy_end", VEND_CYCLES + 1 + 2 * change);
        sb_push("dropped", int'(inject));

        @(negedge clk_i);
        soda_i   = 1'b1;
        change_i = CHANGE_W'(change);
        v[0] = 0; e[0] = 0; c[0] = 0; b[0] = 0;
        for (int i = 1; i <= TRACE_LEN; i++) begin
            @(negedge clk_i);
            v[i] = int'(vend_o);
            e[i] = int'(eject_o);
            c[i] = int'(coins_left_o);
            b[i] = int'(busy_o);
            eject_ack_i = eject_o;
            soda_i      = (i < hold_len) || (inject && i == 3);
            change_i    = CHANGE_W'($urandom_range(0, 7));
        end
        eject_ack_i = 1'b0;
        soda_i      = 1'b0;

        vend_lat = -1; vend_len = 0; vend_runs = 0;
        for (int i = 1; i <= TRACE_LEN; i++) begin
            if (v[i] != 0 && v[i-1] == 0) vend_runs++;
            if (v[i] != 0 && vend_lat < 0) vend_lat = i;
            if (v[i] != 0 && vend_runs == 1) vend_len++;
        end
        sb_obs("vend_lat", vend_lat);
        sb_obs("vend_len", vend_len);
        sb_obs("vend_runs", vend_runs);

        pulses = 0; first = 1'b1; t = 1;
        while (t <= TRACE_LEN) begin
            if (e[t] != 0) begin
                if (first) sb_obs("eject_lat", t);
                else       sb_obs("gap_len", t - fall);
                first = 1'b0;
                len = 0;
                while (t <= TRACE_LEN && e[t] != 0) begin
                    len++;
                    t++;
                end
                fall = t;
                pulses++;
                sb_obs("eject_len", len);
                sb_obs("coins_after", (t <= TRACE_LEN) ? c[t] : -1);
            end else begin
                t++;
            end
        end
        sb_obs("eject_count", pulses);

        busy_end = TRACE_LEN + 1;
        for (int i = TRACE_LEN; i >= 2; i--)
            if (b[i] == 0 && b[i-1] != 0) busy_end = i;
        sb_obs("busy_end", busy_end);
        sb_obs("dropped", int'(dropped_o));
        $display("txn trace change=%0d hold=%0d inject=%0d pulses=%0d", change, hold_len, inject, pulses);
    endtask

    initial begin
        int len;
        int vc;

        // reset state
        repeat (3) @(negedge clk_i);
        sb_push("rst_vend", 0); sb_push("rst_eject", 0); sb_push("rst_busy", 0);
        sb_push("rst_coins", 0); sb_push("rst_fault", 0); sb_push("rst_dropped", 0);
        sb_obs("rst_vend", int'(vend_o));
        sb_obs("rst_eject", int'(eject_o));
        sb_obs("rst_busy", int'(busy_o));
        sb_obs("rst_coins", int'(coins_left_o));
        sb_obs("rst_fault", int'(fault_o));
        sb_obs("rst_dropped", int'(dropped_o));
        $display("txn reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        run_trace(0, 1, 1'b0);
        run_trace(3, 1, 1'b0);
        run_trace(7, 1, 1'b0);
        run_trace(2, 1, 1'b1);
        sb_push("clr_dropped", 0);
        pulse_clr();
        sb_obs("clr_dropped", int'(dropped_o));
        run_trace(1, 5, 1'b0);

        // no ack: timeout, then clear with a simultaneous soda edge
        sb_push("to_eject_seen", 1); sb_push("to_eject_len", ACK_TIMEOUT);
        sb_push("to_fault", 1); sb_push("to_coins", 2); sb_push("to_eject_off", 0); sb_push("to_busy", 1);
        soda_pulse(2);
        wait_eject("to");
        len = 0;
        while (eject_o && len < ACK_TIMEOUT + 50) begin
            len++;
            @(negedge clk_i);
        end
        sb_obs("to_eject_len", len);
        sb_obs("to_fault", int'(fault_o));
        sb_obs("to_coins", int'(coins_left_o));
        sb_obs("to_eject_off", int'(eject_o));
        sb_obs("to_busy", int'(busy_o));
        sb_push("clr_fault", 0); sb_push("clr_busy", 0); sb_push("clr_coins", 0);
        sb_push("clr_dropped", 0); sb_push("clr_vend_cycles", 0);
        fault_clr_i = 1'b1;
        soda_i      = 1'b1;
        change_i    = 3'd5;
        @(negedge clk_i);
        fault_clr_i = 1'b0;
        soda_i      = 1'b0;
        sb_obs("clr_fault", int'(fault_o));
        sb_obs("clr_busy", int'(busy_o));
        sb_obs("clr_coins", int'(coins_left_o));
        sb_obs("clr_dropped", int'(dropped_o));
        vc = int'(vend_o);
        repeat (4) begin
            @(negedge clk_i);
            vc += int'(vend_o);
        end
        sb_obs("clr_vend_cycles", vc);
        $display("txn timeout eject_len=%0d", len);

        // hopper empty while owing
        sb_push("em_eject_seen", 1); sb_push("em_fault", 1); sb_push("em_coins", 4); sb_push("em_eject", 0);
        soda_pulse(4);
        wait_eject("em");
        hopper_empty_i = 1'b1;
        @(negedge clk_i);
        hopper_empty_i = 1'b0;
        sb_obs("em_fault", int'(fault_o));
        sb_obs("em_coins", int'(coins_left_o));
        sb_obs("em_eject", int'(eject_o));
        pulse_clr();
        $display("txn empty coins=%0d", coins_left_o);

        // ack and empty together: ack wins
        sb_push("ae_eject_seen", 1); sb_push("ae_fault", 0); sb_push("ae_coins", 1); sb_push("ae_eject", 0);
        sb_push("ae2_eject_seen", 1); sb_push("ae_coins_end", 0); sb_push("ae_busy_end", 0);
        soda_pulse(2);
        wait_eject("ae");
        eject_ack_i    = 1'b1;
        hopper_empty_i = 1'b1;
        @(negedge clk_i);
        eject_ack_i    = 1'b0;
        hopper_empty_i = 1'b0;
        sb_obs("ae_fault", int'(fault_o));
        sb_obs("ae_coins", int'(coins_left_o));
        sb_obs("ae_eject", int'(eject_o));
        wait_eject("ae2");
        eject_ack_i = 1'b1;
        @(negedge clk_i);
        eject_ack_i = 1'b0;
        sb_obs("ae_coins_end", int'(coins_left_o));
        @(negedge clk_i);
        sb_obs("ae_busy_end", int'(busy_o));
        $display("txn ack_and_empty");

        // asynchronous reset in the middle of an ejection
        sb_push("ar_eject_seen", 1); sb_push("ar_eject2_seen", 1); sb_push("ar_pre_coins", 4);
        sb_push("ar_eject", 0); sb_push("ar_busy", 0); sb_push("ar_coins", 0); sb_push("ar_fault", 0); sb_push("ar_vend", 0);
        soda_pulse(5);
        wait_eject("ar");
        eject_ack_i = 1'b1;
        @(negedge clk_i);
        eject_ack_i = 1'b0;
        wait_eject("ar2");
        sb_obs("ar_pre_coins", int'(coins_left_o));
        #2;
        rst_ni = 1'b0;
        #1;
        sb_obs("ar_eject", int'(eject_o));
        sb_obs("ar_busy", int'(busy_o));
        sb_obs("ar_coins", int'(coins_left_o));
        sb_obs("ar_fault", int'(fault_o));
        sb_obs("ar_vend", int'(vend_o));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        $display("txn async_reset");

        run_trace(1, 1, 1'b0);

        check("sb_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
